// File: rtl/jtframe_bank_pkg.sv
// rtl/jtframe_bank_pkg.sv - shared types and constants for the SDRAM bank slot arbiter
// Purpose: FSM state encoding, watchdog counter width and an index helper
//          shared by jtframe_bank_slots and jtframe_bank_pick.
// Ports:   none (package).
package jtframe_bank_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } bank_state_e;

    // Watchdog counter width; TOUT must fit in it.
    localparam int TOUT_W = 8;

    // (a + b) modulo n, used to walk slot indices circularly.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/jtframe_bank_pick.sv
// rtl/jtframe_bank_pick.sv - combinational winner selection among pending slots
// Purpose: picks one pending slot. With JTFRAME_BANK_RR_EN defined the search
//          starts at ptr and wraps; otherwise the lowest pending index wins and
//          there is no ptr port.
// Ports:   pend - pending request per slot
//          ptr  - first slot to consider (JTFRAME_BANK_RR_EN only)
//          any  - at least one slot pending
//          win  - index of the selected slot (valid when any=1)
module jtframe_bank_pick
    import jtframe_bank_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int PW    = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0] pend,
`ifdef JTFRAME_BANK_RR_EN
    input  logic [PW-1:0]    ptr,
`endif
    output logic             any,
    output logic [PW-1:0]    win
);

    always_comb begin
        any = 1'b0;
        win = '0;
        // Scan from the least preferred candidate up, so the most preferred
        // pending slot is the last one assigned.
        for (int k = SLOTS - 1; k >= 0; k--) begin
            logic [PW-1:0] idx;
`ifdef JTFRAME_BANK_RR_EN
            idx = PW'(wrap_add(int'(ptr), k, SLOTS));
`else
            idx = PW'(k);
`endif
            if (pend[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/jtframe_bank_slots.sv
// rtl/jtframe_bank_slots.sv - shares one SDRAM bank read port among cached ROM slots
// Purpose: each slot keeps its last fetched word; misses are arbitrated onto the
//          bank read port (fixed priority, or round-robin with JTFRAME_BANK_RR_EN).
//          A watchdog aborts accesses that stay in WAIT_ACK/WAIT_RDY too long.
// Ports:   clk, rst (sync, active high), downloading (flush caches, block grants)
//          slot_addr/slot_cs in, slot_ok/slot_dout out (per-slot packed vectors)
//          ba_addr/ba_rd out, ba_ack/ba_rdy/sdram_dout in (bank interface)
//          timeout out (one-cycle pulse on watchdog abort)
module jtframe_bank_slots
    import jtframe_bank_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int SDRAMW = 22,
    parameter int DW     = 16,
    parameter int TOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    downloading,
    input  logic [SLOTS*SDRAMW-1:0] slot_addr,
    input  logic [SLOTS-1:0]        slot_cs,
    output logic [SLOTS-1:0]        slot_ok,
    output logic [SLOTS*DW-1:0]     slot_dout,
    output logic [SDRAMW-1:0]       ba_addr,
    output logic                    ba_rd,
    input  logic                    ba_ack,
    input  logic                    ba_rdy,
    input  logic [DW-1:0]           sdram_dout,
    output logic                    timeout
);
    localparam int PW = $clog2(SLOTS);

    bank_state_e       state_q, state_d;
    logic [SDRAMW-1:0] ba_addr_q, ba_addr_d;
    logic              ba_rd_q, ba_rd_d;
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic [SDRAMW-1:0] addr_q [SLOTS];
    logic [SDRAMW-1:0] addr_d [SLOTS];
    logic [DW-1:0]     dout_q [SLOTS];
    logic [DW-1:0]     dout_d [SLOTS];
    logic              timeout_q, timeout_d;
    logic [PW-1:0]     cur_q, cur_d;
    logic [TOUT_W-1:0] wdog_q, wdog_d;

    logic [SDRAMW-1:0] req_addr [SLOTS];
    logic [SLOTS-1:0]  hit, pend;
    logic              any;
    logic [PW-1:0]     win;
    logic              grant, store, abort, acked, wdog_hit;

    // Last permitted wait cycle: the abort lands TOUT cycles after ba_rd rose.
    assign wdog_hit = wdog_q == TOUT_W'(TOUT - 1);

    always_comb begin
        hit       = '0;
        pend      = '0;
        slot_ok   = '0;
        slot_dout = '0;
        for (int i = 0; i < SLOTS; i++) begin
            req_addr[i] = slot_addr[i*SDRAMW +: SDRAMW];
            hit[i]      = valid_q[i] && (addr_q[i] == req_addr[i]);
            // The slot being served is not pending again until it finishes.
            pend[i]     = slot_cs[i] && !hit[i] && !(state_q != IDLE && cur_q == PW'(i));
            slot_ok[i]  = slot_cs[i] && hit[i];
            slot_dout[i*DW +: DW] = dout_q[i];
        end
    end

`ifdef JTFRAME_BANK_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant) ptr_d = PW'(wrap_add(int'(win), 1, SLOTS));
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    jtframe_bank_pick #(.SLOTS(SLOTS), .PW(PW)) u_pick (
        .pend (pend),
        .ptr  (ptr_q),
        .any  (any),
        .win  (win)
    );
`else
    jtframe_bank_pick #(.SLOTS(SLOTS), .PW(PW)) u_pick (
        .pend (pend),
        .any  (any),
        .win  (win)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        store   = 1'b0;
        abort   = 1'b0;
        acked   = 1'b0;
        unique case (state_q)
            IDLE: if (!downloading && any) begin
                grant   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // ack and rdy together: accept the data right away.
                if (ba_ack && ba_rdy) begin
                    store   = 1'b1;
                    state_d = IDLE;
                end else if (ba_ack) begin
                    acked   = 1'b1;
                    state_d = WAIT_RDY;
                end else if (wdog_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_RDY: begin
                if (ba_rdy) begin
                    store   = 1'b1;
                    state_d = IDLE;
                end else if (wdog_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ba_addr_d = ba_addr_q;
        ba_rd_d   = ba_rd_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        cur_d     = cur_q;
        timeout_d = 1'b0;
        wdog_d    = (state_q == IDLE) ? '0 : wdog_q + 1'b1;
        if (grant) begin
            ba_addr_d     = req_addr[win];
            ba_rd_d       = 1'b1;
            addr_d[win]   = req_addr[win];
            valid_d[win]  = 1'b0;
            cur_d         = win;
            wdog_d        = '0;
        end
        if (acked) ba_rd_d = 1'b0;
        if (store) begin
            dout_d[cur_q]  = sdram_dout;
            valid_d[cur_q] = 1'b1;
            ba_rd_d        = 1'b0;
        end
        if (abort) begin
            ba_rd_d   = 1'b0;
            timeout_d = 1'b1;
        end
        // A download rewrites the ROM, so nothing cached may be trusted.
        if (downloading) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ba_addr_q <= '0;
            ba_rd_q   <= 1'b0;
            valid_q   <= '0;
            timeout_q <= 1'b0;
            cur_q     <= '0;
            wdog_q    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                addr_q[i] <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            ba_addr_q <= ba_addr_d;
            ba_rd_q   <= ba_rd_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cur_q     <= cur_d;
            wdog_q    <= wdog_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
        end
    end

    assign ba_addr = ba_addr_q;
    assign ba_rd   = ba_rd_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_jtframe_bank_slots.sv
// tb/tb_jtframe_bank_slots.sv - self-checking bench for jtframe_bank_slots
module tb_jtframe_bank_slots;
    localparam int SLOTS  = 4;
    localparam int SDRAMW = 22;
    localparam int DW     = 16;
    localparam int TOUT   = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, downloading;
    logic [SLOTS*SDRAMW-1:0] slot_addr;
    logic [SLOTS-1:0]        slot_cs, slot_ok;
    logic [SLOTS*DW-1:0]     slot_dout;
    logic [SDRAMW-1:0]       ba_addr;
    logic                    ba_rd, ba_ack, ba_rdy, timeout;
    logic [DW-1:0]           sdram_dout;

    logic          resp_en, m_ack, m_rdy, r_ack, r_rdy;
    logic [DW-1:0] m_dout, r_dout;
    logic [SDRAMW-1:0] resp_a;
    assign ba_ack     = resp_en ? r_ack  : m_ack;
    assign ba_rdy     = resp_en ? r_rdy  : m_rdy;
    assign sdram_dout = resp_en ? r_dout : m_dout;

    jtframe_bank_slots #(.SLOTS(SLOTS), .SDRAMW(SDRAMW), .DW(DW), .TOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_addr(slot_addr), .slot_cs(slot_cs), .slot_ok(slot_ok), .slot_dout(slot_dout),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
        .sdram_dout(sdram_dout), .timeout(timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int s, input logic [SDRAMW-1:0] a);
        slot_addr[s*SDRAMW +: SDRAMW] = a;
    endtask

    function automatic logic [DW-1:0] get_dout(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    // Reference ROM contents: a fixed arithmetic hash of the word address.
    function automatic logic [DW-1:0] mem_word(input logic [SDRAMW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503;
        return t[23:8] ^ a[15:0];
    endfunction

    function automatic logic [SDRAMW-1:0] slot_a(input int s, input int r);
        return SDRAMW'((s + 1) * 256 + r);
    endfunction

    function automatic int slot_of(input logic [SDRAMW-1:0] a);
        return int'(a >> 8) - 1;
    endfunction

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        while (!ba_rd && n < 20) begin
            step();
            n++;
        end
        chk({name, "_rd"}, 32'(ba_rd), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
        m_ack = 1'b0; m_rdy = 1'b0; m_dout = '0; resp_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Grant monitor: records the address of every new bank request.
    logic [SDRAMW-1:0] grants [$];
    logic mon_prev = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ba_rd && !mon_prev) grants.push_back(ba_addr);
            mon_prev = ba_rd;
        end
    end

    // Random-latency SDRAM model used when resp_en is set.
    initial begin
        r_ack = 1'b0; r_rdy = 1'b0; r_dout = '0; resp_a = '0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_en && ba_rd) begin
                resp_a = ba_addr;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                r_ack = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    r_rdy = 1'b1; r_dout = mem_word(resp_a);
                end
                @(posedge clk); #2;
                r_ack = 1'b0;
                if (!r_rdy) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                    r_rdy = 1'b1; r_dout = mem_word(resp_a);
                    @(posedge clk); #2;
                end
                r_rdy = 1'b0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        int                slot;
        logic [SDRAMW-1:0] addr;
        int                ack_dly;
        int                rdy_dly;   // 0: rdy together with ack
        logic [DW-1:0]     data;
        bit                miss;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n, base, nz;
        logic rd_seen;
        logic [SDRAMW-1:0] a0;
        logic [SDRAMW-1:0] pool [4];
        logic [SDRAMW-1:0] last_a [SLOTS];
        logic [SDRAMW-1:0] cur_a [SLOTS];
        bit known [SLOTS];

        vecs[0] = '{0, 22'h001234, 2, 4, 16'hBEEF, 1'b1};
        vecs[1] = '{0, 22'h001234, 0, 0, 16'hBEEF, 1'b0};
        vecs[2] = '{2, 22'h3FFFFF, 0, 0, 16'h0001, 1'b1};
        vecs[3] = '{2, 22'h3FFFFF, 0, 0, 16'h0001, 1'b0};
        vecs[4] = '{3, 22'h000000, 1, 1, 16'hFFFF, 1'b1};
        vecs[5] = '{0, 22'h001234, 0, 0, 16'hBEEF, 1'b0};
        vecs[6] = '{0, 22'h001235, 0, 2, 16'h1111, 1'b1};
        vecs[7] = '{0, 22'h001234, 3, 0, 16'hBEEF, 1'b1};

        // Reset state, checked while reset is held with every slot requesting address 0.
        rst = 1'b1; downloading = 1'b0; slot_cs = '1; slot_addr = '0;
        m_ack = 1'b0; m_rdy = 1'b0; m_dout = '0; resp_en = 1'b0;
        repeat (3) step();
        chk("rst_ok",      32'(slot_ok),    32'd0);
        chk("rst_rd",      32'(ba_rd),      32'd0);
        chk("rst_addr",    32'(ba_addr),    32'd0);
        chk("rst_timeout", 32'(timeout),    32'd0);
        chk("rst_dout",    32'(|slot_dout), 32'd0);
        slot_cs = '0;
        step();
        rst = 1'b0;
        step();

        // Table-driven single-slot accesses.
        for (int v = 0; v < 8; v++) begin
            slot_cs = '0;
            slot_cs[vecs[v].slot] = 1'b1;
            set_addr(vecs[v].slot, vecs[v].addr);
            settle();
            if (!vecs[v].miss) begin
                chk("hit_ok",   32'(slot_ok[vecs[v].slot]),   32'd1);
                chk("hit_dout", 32'(get_dout(vecs[v].slot)), 32'(vecs[v].data));
                rd_seen = 1'b0;
                repeat (4) begin step(); rd_seen |= ba_rd; end
                chk("hit_no_rd", 32'(rd_seen), 32'd0);
            end else begin
                chk("miss_ok0", 32'(slot_ok[vecs[v].slot]), 32'd0);
                wait_rd("miss");
                chk("miss_addr", 32'(ba_addr), 32'(vecs[v].addr));
                repeat (vecs[v].ack_dly) step();
                m_ack = 1'b1;
                if (vecs[v].rdy_dly == 0) begin m_rdy = 1'b1; m_dout = vecs[v].data; end
                step();
                m_ack = 1'b0; m_rdy = 1'b0;
                if (vecs[v].rdy_dly > 0) begin
                    repeat (vecs[v].rdy_dly - 1) step();
                    m_rdy = 1'b1; m_dout = vecs[v].data;
                    step();
                    m_rdy = 1'b0;
                end
                settle();
                chk("miss_ok",   32'(slot_ok[vecs[v].slot]),   32'd1);
                chk("miss_dout", 32'(get_dout(vecs[v].slot)), 32'(vecs[v].data));
                chk("miss_rd0",  32'(ba_rd),                  32'd0);
            end
        end

        // Watchdog: acked but never ready.
        slot_cs = 4'b0010; set_addr(1, 22'h000055);
        wait_rd("tout");
        n = 0;
        m_ack = 1'b1;
        step(); n++;
        m_ack = 1'b0;
        while (!timeout && n < 400) begin step(); n++; end
        chk("tout_cycles", 32'(n),          32'(TOUT));
        chk("tout_rd",     32'(ba_rd),      32'd0);
        chk("tout_ok",     32'(slot_ok[1]), 32'd0);
        step();
        chk("tout_pulse",  32'(timeout),    32'd0);
        chk("tout_retry",  32'(ba_rd),      32'd1);
        chk("tout_raddr",  32'(ba_addr),    32'h55);
        m_ack = 1'b1; m_rdy = 1'b1; m_dout = 16'hA5A5;
        step();
        m_ack = 1'b0; m_rdy = 1'b0;
        settle();
        chk("tout_done",   32'(get_dout(1)), 32'hA5A5);

        // Download starts while a read waits for data.
        slot_cs = 4'b0101; set_addr(0, 22'h000777);
        settle();
        chk("dl_pre_hit", 32'(slot_ok[2]), 32'd1);
        wait_rd("dl");
        chk("dl_addr", 32'(ba_addr), 32'h777);
        m_ack = 1'b1; step(); m_ack = 1'b0;
        downloading = 1'b1; step();
        m_rdy = 1'b1; m_dout = 16'h4321; step(); m_rdy = 1'b0;
        settle();
        chk("dl_ok",   32'(slot_ok),     32'd0);
        chk("dl_dout", 32'(get_dout(0)), 32'h4321);
        rd_seen = 1'b0;
        repeat (6) begin step(); rd_seen |= ba_rd; end
        chk("dl_no_rd", 32'(rd_seen), 32'd0);
        slot_cs = 4'b0001; downloading = 1'b0;
        wait_rd("dl_after");
        chk("dl_refetch", 32'(ba_addr), 32'h777);
        m_ack = 1'b1; m_rdy = 1'b1; m_dout = 16'h4321; step();
        m_ack = 1'b0; m_rdy = 1'b0;
        settle();
        chk("dl_ok_after", 32'(slot_ok[0]), 32'd1);

        // Address changes while the read waits for data.
        slot_cs = 4'b0010; set_addr(1, 22'h000010);
        settle();
        chk("chg_ok0", 32'(slot_ok[1]), 32'd0);
        wait_rd("chg");
        chk("chg_addr1", 32'(ba_addr), 32'h10);
        m_ack = 1'b1; step(); m_ack = 1'b0;
        set_addr(1, 22'h000020); step();
        m_rdy = 1'b1; m_dout = 16'h1010; step(); m_rdy = 1'b0;
        settle();
        chk("chg_ok_old", 32'(slot_ok[1]), 32'd0);
        wait_rd("chg2");
        chk("chg_addr2", 32'(ba_addr), 32'h20);
        m_ack = 1'b1; m_rdy = 1'b1; m_dout = 16'h2020; step();
        m_ack = 1'b0; m_rdy = 1'b0;
        settle();
        chk("chg_ok_new",   32'(slot_ok[1]),   32'd1);
        chk("chg_dout_new", 32'(get_dout(1)), 32'h2020);
        set_addr(1, 22'h000010);
        settle();
        chk("chg_evicted", 32'(slot_ok[1]), 32'd0);

        // Arbitration order with all slots missing.
        do_reset();
        resp_en = 1'b1;
        base = grants.size();
`ifdef JTFRAME_BANK_RR_EN
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < SLOTS; i++) set_addr(i, slot_a(i, r));
            slot_cs = '1;
            settle();
            n = 0;
            while (slot_ok != '1 && n < 500) begin step(); n++; end
            chk("rr_all_ok", 32'(slot_ok), 32'hF);
        end
        chk("rr_count", 32'(grants.size() - base), 32'd8);
        for (int k = 0; k < 8; k++)
            if (base + k < grants.size())
                chk("rr_order", 32'(slot_of(grants[base + k])), 32'(k % SLOTS));
`else
        for (int i = 0; i < SLOTS; i++) set_addr(i, slot_a(i, 0));
        a0 = slot_a(0, 0);
        slot_cs = '1;
        settle();
        for (int it = 0; it < 6; it++) begin
            n = 0;
            while (!slot_ok[0] && n < 200) begin step(); n++; end
            chk("fix_ok0", 32'(slot_ok[0]), 32'd1);
            a0 = a0 ^ 22'h1;
            set_addr(0, a0);
            settle();
        end
        chk("fix_starved", 32'(slot_ok[3]), 32'd0);
        chk("fix_count", 32'(grants.size() - base >= 6), 32'd1);
        nz = 0;
        for (int k = base; k < grants.size(); k++)
            if (slot_of(grants[k]) != 0) nz++;
        chk("fix_only0", 32'(nz), 32'd0);
`endif
        slot_cs = '0;
        repeat (30) step();

        // Randomized traffic against a one-word-per-slot cache model.
        do_reset();
        resp_en = 1'b1;
        pool[0] = 22'h000000; pool[1] = 22'h000001;
        pool[2] = 22'h3FFFFF; pool[3] = 22'h2AAAAA;
        for (int i = 0; i < SLOTS; i++) begin known[i] = 1'b0; last_a[i] = '0; end
        for (int round = 0; round < 40; round++) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_cs[i] = ($urandom_range(0, 3) != 0);
                cur_a[i]   = pool[$urandom_range(0, 3)];
                set_addr(i, cur_a[i]);
            end
            settle();
            for (int i = 0; i < SLOTS; i++)
                chk("rnd_hit", 32'(slot_ok[i]),
                    32'(slot_cs[i] && known[i] && last_a[i] == cur_a[i]));
            n = 0;
            while ((slot_ok & slot_cs) != slot_cs && n < 2000) begin step(); n++; end
            chk("rnd_done", 32'((slot_ok & slot_cs) == slot_cs), 32'd1);
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_cs[i]) begin
                    chk("rnd_data", 32'(get_dout(i)), 32'(mem_word(cur_a[i])));
                    known[i]  = 1'b1;
                    last_a[i] = cur_a[i];
                end
            end
            step();
        end
        slot_cs = '0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
